// File: rtl/map_draw_if.sv
// map_draw_if -- request/pixel bundle between a map_draw renderer and its
// surroundings. The renderer takes the slave side: it receives the draw
// request and drives the VGA-adapter pixel outputs. The requester or
// testbench takes the master side.
interface map_draw_if;
    logic       start;
    logic       map_select;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] col_out;
    logic       oPlot;
    logic       busy;
    logic       done;

    modport master (
        output start,
        output map_select,
        input  x_out,
        input  y_out,
        input  col_out,
        input  oPlot,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  map_select,
        output x_out,
        output y_out,
        output col_out,
        output oPlot,
        output busy,
        output done
    );
endinterface

// File: rtl/map_draw.sv
// map_draw -- walks the whole screen in raster order, one pixel per clock,
// and colours each pixel from the selected map. Map 0 is a bordered room.
// Map 1 adds a solid central block of wall.
// Build option: define MAP_DRAW_CLEAR_PASS_EN to insert a black clear pass
// (state CLEAR) ahead of the map pass. The clear pass runs directly into
// the map pass with no gap cycle.
// The x/y counters drive x_out/y_out directly. That keeps the outputs
// registered and holds the last emitted pixel while oPlot is low.
module map_draw #(
    parameter int         WIDTH     = 160,
    parameter int         HEIGHT    = 120,
    parameter logic [2:0] WALL_COL  = 3'b111,
    parameter logic [2:0] FLOOR_COL = 3'b000
) (
    input  logic      clk,
    input  logic      resetn,
    map_draw_if.slave bus
);
    localparam logic [7:0] X_LAST   = 8'(WIDTH - 1);
    localparam logic [6:0] Y_LAST   = 7'(HEIGHT - 1);
    localparam logic [7:0] BOX_X_LO = 8'(WIDTH / 2 - 20);
    localparam logic [7:0] BOX_X_HI = 8'(WIDTH / 2 + 19);
    localparam logic [6:0] BOX_Y_LO = 7'(HEIGHT / 2 - 10);
    localparam logic [6:0] BOX_Y_HI = 7'(HEIGHT / 2 + 9);

`ifdef MAP_DRAW_CLEAR_PASS_EN
    typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
`endif

    state_t     r_state;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic       r_map;
    logic [2:0] r_col;
    logic       r_plot;
    logic       r_busy;
    logic       r_done;

    state_t     w_stateNext;
    logic [7:0] w_xNext;
    logic [6:0] w_yNext;
    logic       w_mapNext;
    logic [2:0] w_colNext;
    logic       w_plotNext;
    logic       w_busyNext;
    logic       w_doneNext;

    logic [7:0] w_stepX;
    logic [6:0] w_stepY;
    logic       w_lastPixel;

    // Map colour of a pixel: border walls always; central block only on map 1.
    function automatic logic [2:0] colourOf(input logic mapSel,
                                            input logic [7:0] px,
                                            input logic [6:0] py);
        logic border;
        logic block;
        border = (px == 8'd0) || (px == X_LAST) || (py == 7'd0) || (py == Y_LAST);
        block  = mapSel && (px >= BOX_X_LO) && (px <= BOX_X_HI)
                        && (py >= BOX_Y_LO) && (py <= BOX_Y_HI);
        return (border || block) ? WALL_COL : FLOOR_COL;
    endfunction

    // Raster successor of the current pixel. x wraps to 0 exactly at the last column.
    always_comb begin
        w_stepX     = (r_x == X_LAST) ? 8'd0 : r_x + 8'd1;
        w_stepY     = (r_x == X_LAST) ? r_y + 7'd1 : r_y;
        w_lastPixel = (r_x == X_LAST) && (r_y == Y_LAST);
    end

    // Next-state and next-output logic. Every output is recomputed here and registered below.
    always_comb begin
        w_stateNext = r_state;
        w_xNext     = r_x;
        w_yNext     = r_y;
        w_mapNext   = r_map;
        w_colNext   = r_col;
        w_plotNext  = 1'b0;
        w_busyNext  = 1'b0;
        w_doneNext  = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_mapNext  = bus.map_select;
                    w_xNext    = 8'd0;
                    w_yNext    = 7'd0;
                    w_plotNext = 1'b1;
                    w_busyNext = 1'b1;
`ifdef MAP_DRAW_CLEAR_PASS_EN
                    w_stateNext = CLEAR;
                    w_colNext   = 3'b000;
`else
                    w_stateNext = DRAW;
                    w_colNext   = colourOf(bus.map_select, 8'd0, 7'd0);
`endif
                end
            end
`ifdef MAP_DRAW_CLEAR_PASS_EN
            CLEAR: begin
                w_plotNext = 1'b1;
                w_busyNext = 1'b1;
                if (w_lastPixel) begin
                    w_stateNext = DRAW;
                    w_xNext     = 8'd0;
                    w_yNext     = 7'd0;
                    w_colNext   = colourOf(r_map, 8'd0, 7'd0);
                end else begin
                    w_xNext   = w_stepX;
                    w_yNext   = w_stepY;
                    w_colNext = 3'b000;
                end
            end
`endif
            DRAW: begin
                if (w_lastPixel) begin
                    w_stateNext = DONE;
                    w_doneNext  = 1'b1;
                end else begin
                    w_plotNext = 1'b1;
                    w_busyNext = 1'b1;
                    w_xNext    = w_stepX;
                    w_yNext    = w_stepY;
                    w_colNext  = colourOf(r_map, w_stepX, w_stepY);
                end
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Counter, latched map and registered pixel outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x    <= 8'd0;
            r_y    <= 7'd0;
            r_map  <= 1'b0;
            r_col  <= 3'b000;
            r_plot <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_x    <= w_xNext;
            r_y    <= w_yNext;
            r_map  <= w_mapNext;
            r_col  <= w_colNext;
            r_plot <= w_plotNext;
            r_busy <= w_busyNext;
            r_done <= w_doneNext;
        end
    end

    assign bus.x_out   = r_x;
    assign bus.y_out   = r_y;
    assign bus.col_out = r_col;
    assign bus.oPlot   = r_plot;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_map_draw.sv
// tb_map_draw -- randomized self-checking bench for map_draw.
// The expected screen is painted into bitmaps (border rows and columns,
// then the central block for map 1). Every output cycle is predicted from
// the pixel's raster index.
module tb_map_draw;
    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;
`ifdef MAP_DRAW_CLEAR_PASS_EN
    localparam int TOTAL     = 2 * N;
    localparam bit HAS_CLEAR = 1'b1;
`else
    localparam int TOTAL     = N;
    localparam bit HAS_CLEAR = 1'b0;
`endif

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    int   checks = 0;
    int   passes = 0;
    bit   wallMap [0:1][0:N-1];

    map_draw_if bus();

    map_draw #(
        .WIDTH    (W),
        .HEIGHT   (H),
        .WALL_COL (3'b111),
        .FLOOR_COL(3'b000)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Paint both reference screens: floor everywhere, border walls, then the map-1 block.
    task automatic paintMaps();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++) wallMap[m][i] = 1'b0;
            for (int x = 0; x < W; x++) begin
                wallMap[m][x] = 1'b1;
                wallMap[m][(H - 1) * W + x] = 1'b1;
            end
            for (int y = 0; y < H; y++) begin
                wallMap[m][y * W] = 1'b1;
                wallMap[m][y * W + W - 1] = 1'b1;
            end
        end
        for (int y = H / 2 - 10; y <= H / 2 + 9; y++)
            for (int x = W / 2 - 20; x <= W / 2 + 19; x++)
                wallMap[1][y * W + x] = 1'b1;
    endtask

    // Packed view of everything the DUT drives: {oPlot,busy,done,x,y,col}.
    function automatic logic [20:0] sampleOutputs();
        return {bus.oPlot, bus.busy, bus.done, bus.x_out, bus.y_out, bus.col_out};
    endfunction

    // Expected outputs k cycles after the accepting edge of a draw with latched map mapSel.
    function automatic logic [20:0] expectedOut(input bit mapSel, input int k);
        int p;
        int q;
        int x;
        int y;
        logic [2:0] col;
        logic plot;
        logic busy;
        logic done;
        if (k <= TOTAL) begin
            p    = k - 1;
            q    = p % N;
            x    = q % W;
            y    = q / W;
            col  = (HAS_CLEAR && p < N) ? 3'b000 : (wallMap[mapSel][q] ? 3'b111 : 3'b000);
            plot = 1'b1;
            busy = 1'b1;
            done = 1'b0;
        end else begin
            x    = W - 1;
            y    = H - 1;
            col  = wallMap[mapSel][N - 1] ? 3'b111 : 3'b000;
            plot = 1'b0;
            busy = 1'b0;
            done = (k == TOTAL + 1);
        end
        return {plot, busy, done, 8'(x), 7'(y), col};
    endfunction

    // Count one comparison and report it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [20:0] observed,
                               input logic [20:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    endtask

    // Drive the request inputs; they are sampled at the next rising edge.
    task automatic applyStimulus(input logic s, input logic m);
        bus.start      = s;
        bus.map_select = m;
    endtask

    // Follow a draw cycle by cycle from the accepting edge and check every output.
    // Inputs wiggle during the pass because the DUT must ignore them there.
    task automatic followDraw(input bit mapSel, input int lastK, input int toggleAt,
                              input bit holdStart, input bit chainStart, input bit chainMap);
        for (int k = 1; k <= lastK; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("map%0d_cyc%0d", mapSel, k), sampleOutputs(), expectedOut(mapSel, k));
            if (k <= TOTAL) begin
                if (holdStart) begin
                    bus.start = 1'b1;
                    if (k - 1 == toggleAt) bus.map_select = ~bus.map_select;
                end else begin
                    applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            end else if (k == TOTAL + 1) begin
                applyStimulus(chainStart, chainMap);
            end
        end
    endtask

    // Assert reset between edges, check outputs clear at once, then release and confirm nothing restarts.
    task automatic doReset(input string tag);
        bus.start = 1'b0;
        resetn    = 1'b0;
        #1;
        checkOutput({tag, "_async"}, sampleOutputs(), 21'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_held"}, sampleOutputs(), 21'd0);
        resetn = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_idle"}, sampleOutputs(), 21'd0);
        end
    endtask

    // Main sequence: reset, chained map0/map1 draws, mid-pass resets and a redraw.
    initial begin
        int  cutK;
        bit  m;
        paintMaps();
        applyStimulus(1'b0, 1'b0);

        #3 resetn = 1'b0;
        #1 checkOutput("por_async", sampleOutputs(), 21'd0);
        repeat (2) @(posedge clk);
        #1 checkOutput("por_held", sampleOutputs(), 21'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1 checkOutput("por_idle", sampleOutputs(), 21'd0);

        // Map 0 with start held high and map_select flipped mid-pass; the held start
        // relaunches after one idle cycle with map_select=1.
        applyStimulus(1'b1, 1'b0);
        followDraw(1'b0, TOTAL + 2, 5000 + int'($urandom_range(0, 50)), 1'b1, 1'b1, 1'b1);

        // Map 1 draw, cut by reset once the central block has been drawn.
        cutK = (HAS_CLEAR ? N : 0) + 11140 + int'($urandom_range(1, 500));
        followDraw(1'b1, cutK, -1, 1'b0, 1'b0, 1'b0);
        doReset("cut_map1");

        // Random map, reset near pixel 1000.
        m = 1'($urandom_range(0, 1));
        applyStimulus(1'b1, m);
        followDraw(m, 1000 + int'($urandom_range(0, 200)), -1, 1'b0, 1'b0, 1'b0);
        doReset("cut_1000");

        // Fresh start after reset must begin again at (0,0).
        m = 1'($urandom_range(0, 1));
        applyStimulus(1'b1, m);
        followDraw(m, 20 + int'($urandom_range(0, 40)), -1, 1'b0, 1'b0, 1'b0);
        doReset("cut_redraw");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/map_draw.md
MAP_DRAW -- requirements
Module: map_draw

Interface
REQ-001 SHALL have parameter WIDTH, default 160, screen width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 120, screen height in pixels.
REQ-003 SHALL have parameter WALL_COL, default 3'b111, wall pixel colour.
REQ-004 SHALL have parameter FLOOR_COL, default 3'b000, floor pixel colour.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  level request to draw the selected map.
REQ-008 SHALL have port map_select  input  1  map index from upstream MapSelect: 0 = map0, 1 = map1.
REQ-009 SHALL have port x_out  output  8  pixel column to VGA adapter.
REQ-010 SHALL have port y_out  output  7  pixel row to VGA adapter.
REQ-011 SHALL have port col_out  output  3  pixel colour.
REQ-012 SHALL have port oPlot  output  1  pixel write strobe.
REQ-013 SHALL have port busy  output  1  high while pixels are being emitted.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, DRAW, DONE (plus CLEAR when configured); all outputs registered.
REQ-016 SHALL in IDLE, on a cycle with start=1, latch map_select, zero the x/y counters, and enter the first pass state.
REQ-017 SHALL ignore start and map_select changes in every state other than IDLE.
REQ-018 SHALL emit exactly one pixel per clock in a pass state: oPlot=1, x_out/y_out = current counter, raster order, x fastest (x 0..WIDTH-1, then y+1).
REQ-019 SHALL assert oPlot for the first pixel (0,0) the cycle after start is accepted (latency 1).
REQ-020 SHALL in DRAW colour a pixel WALL_COL when x==0, x==WIDTH-1, y==0 or y==HEIGHT-1; else FLOOR_COL, for map 0.
REQ-021 SHALL for map 1 additionally colour WALL_COL every pixel with x in [WIDTH/2-20, WIDTH/2+19] and y in [HEIGHT/2-10, HEIGHT/2+9] (60..99, 50..69 at defaults).
REQ-022 SHALL, after pixel (WIDTH-1,HEIGHT-1) of DRAW, enter DONE: oPlot=0, busy=0, done=1 for exactly one cycle, then IDLE.
REQ-023 SHALL hold busy=1 on every cycle oPlot=1 and only then; oPlot=0 and done=0 in IDLE.
REQ-024 SHALL hold x_out/y_out/col_out at last emitted values while oPlot=0 (outside reset).
REQ-025 SHALL, if start=1 in DONE, not accept it; start still high in the following IDLE cycle starts a new draw.
REQ-026 SHALL size counters so x never exceeds WIDTH-1 and y never exceeds HEIGHT-1 (no wrap glitch pixel).

Reset
REQ-027 SHALL on resetn=0, immediately and regardless of clk: state IDLE, counters 0, latched map 0, x_out=0, y_out=0, col_out=0, oPlot=0, busy=0, done=0.
REQ-028 SHALL on reset mid-pass abort without a done pulse; drawing resumes only on a new start after resetn=1.

Configuration
REQ-029 SHALL, when macro MAP_DRAW_CLEAR_PASS_EN is defined, precede DRAW with state CLEAR emitting all WIDTH*HEIGHT pixels with col_out=3'b000, then DRAW starting at (0,0) with no gap cycle (oPlot continuous, 2*WIDTH*HEIGHT pixels, done at cycle 38401 after start at defaults).
REQ-030 SHALL, when MAP_DRAW_CLEAR_PASS_EN is undefined, have no CLEAR state: WIDTH*HEIGHT pixels, done at cycle 19201 after start at defaults.

Verification
REQ-031 SHALL cover: reset, start=1 map_select=0 (no clear) -> oPlot count 19200, (0,0) col 7, (1,1) col 0, (159,60) col 7, done one cycle at start+19201.
REQ-032 SHALL cover: map_select=1 -> (60,50) and (99,69) col 7, (59,50) and (100,69) col 0, (80,0) col 7.
REQ-033 SHALL cover: start accepted with map_select=0, map_select toggled to 1 at pixel 5000 -> (80,60) col 0 (latched map kept).
REQ-034 SHALL cover: resetn low at pixel 1000 -> all outputs 0 asynchronously, no done; next start redraws from (0,0).
REQ-035 SHALL cover: start held high continuously -> done pulse, one IDLE cycle, then new draw with (0,0) oPlot=1.
REQ-036 SHALL cover: MAP_DRAW_CLEAR_PASS_EN defined -> first 19200 pixels col 0, pixel 19201 is (0,0) col 7, done at start+38401.
